// File: rtl/bf16xn_mult_pipe_if.sv
// Valid/ready stream bundle for bf16xn_mult_pipe.
// The flags signal exists only when BF16XN_MULT_FLAGS_EN is defined.
interface bf16xn_mult_pipe_if #(
  parameter int LANES = 2
);
  logic                in_valid;
  logic                in_ready;
  logic [16*LANES-1:0] X;
  logic [16*LANES-1:0] Y;
  logic [LANES-1:0]    lane_en;
  logic                out_valid;
  logic                out_ready;
  logic [16*LANES-1:0] R;
`ifdef BF16XN_MULT_FLAGS_EN
  logic [4*LANES-1:0]  flags;

  modport master (
    output in_valid, X, Y, lane_en, out_ready,
    input  in_ready, out_valid, R, flags
  );
  modport slave (
    input  in_valid, X, Y, lane_en, out_ready,
    output in_ready, out_valid, R, flags
  );
`else
  modport master (
    output in_valid, X, Y, lane_en, out_ready,
    input  in_ready, out_valid, R
  );
  modport slave (
    input  in_valid, X, Y, lane_en, out_ready,
    output in_ready, out_valid, R
  );
`endif
endinterface

// File: rtl/bf16xn_mult_pipe.sv
// Packed-bf16 SIMD multiplier: LANES independent RNE multiplies behind a globally stalled valid/ready pipe.
// Optional per-lane {invalid,overflow,underflow,inexact} flags under BF16XN_MULT_FLAGS_EN.
module bf16xn_mult_pipe #(
  parameter int LANES = 2
) (
  input logic               clk,
  input logic               rst,
  bf16xn_mult_pipe_if.slave s_if
);
  localparam int DATA_W = 16 * LANES;

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_NAN  = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_ZERO = 2'd3;

  // Subnormals count as zero, so inf x subnormal is also an invalid operation.
  function automatic logic [1:0] classify_pair(input logic [15:0] a, input logic [15:0] b);
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
    a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
    a_zero = (a[14:7] == 8'h00);
    b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
    b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
    b_zero = (b[14:7] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) classify_pair = CLS_NAN;
    else if (a_inf || b_inf)                                      classify_pair = CLS_INF;
    else if (a_zero || b_zero)                                    classify_pair = CLS_ZERO;
    else                                                          classify_pair = CLS_NORM;
  endfunction

  // Returns {final exponent (10b signed), rounded mantissa (7b)}.
  function automatic logic [16:0] round_rne(input logic signed [9:0] e, input logic [15:0] p);
    logic [6:0]        mant;
    logic              guard;
    logic              sticky;
    logic [7:0]        msum;
    logic signed [9:0] ef;
    if (p[15]) begin
      mant   = p[14:8];
      guard  = p[7];
      sticky = |p[6:0];
    end else begin
      mant   = p[13:7];
      guard  = p[6];
      sticky = |p[5:0];
    end
    msum = {1'b0, mant} + {7'd0, guard & (sticky | mant[0])};
    ef   = e + $signed({9'd0, p[15]}) + $signed({9'd0, msum[7]});
    round_rne = {ef, msum[6:0]};
  endfunction

  function automatic logic [15:0] sat_pack(input logic s, input logic [1:0] cls, input logic en,
                                           input logic [16:0] rnd);
    logic signed [9:0] ef;
    ef = $signed(rnd[16:7]);
    sat_pack = 16'h0000;
    if (en) begin
      case (cls)
        CLS_NAN:  sat_pack = 16'h7FC0;
        CLS_INF:  sat_pack = {s, 8'hFF, 7'h00};
        CLS_ZERO: sat_pack = {s, 15'h0000};
        default: begin
          if (ef >= 10'sd255)    sat_pack = {s, 8'hFF, 7'h00};
          else if (ef <= 10'sd0) sat_pack = {s, 15'h0000};
          else                   sat_pack = {s, ef[7:0], rnd[6:0]};
        end
      endcase
    end
  endfunction

`ifdef BF16XN_MULT_FLAGS_EN
  function automatic logic [3:0] lane_flags(input logic [1:0] cls, input logic en,
                                            input logic signed [9:0] ef, input logic [15:0] p);
    logic inexact;
    inexact    = p[15] ? (|p[7:0]) : (|p[6:0]);
    lane_flags = 4'b0000;
    if (en) begin
      case (cls)
        CLS_NAN:  lane_flags = 4'b1000;
        CLS_INF:  lane_flags = 4'b0000;
        CLS_ZERO: lane_flags = 4'b0000;
        default: begin
          if (ef >= 10'sd255)    lane_flags = 4'b0101;
          else if (ef <= 10'sd0) lane_flags = 4'b0011;
          else                   lane_flags = {3'b000, inexact};
        end
      endcase
    end
  endfunction
`endif

  logic advance;
  logic vld_p0_q, vld_p1_q, vld_p2_q, out_valid_q;

  logic [DATA_W-1:0] x_p0_q, y_p0_q;
  logic [LANES-1:0]  en_p0_q;

  logic [LANES-1:0]  sgn_p1_d, sgn_p1_q, en_p1_q;
  logic signed [9:0] exp_p1_d [LANES];
  logic signed [9:0] exp_p1_q [LANES];
  logic [7:0]        sx_p1_d  [LANES];
  logic [7:0]        sx_p1_q  [LANES];
  logic [7:0]        sy_p1_d  [LANES];
  logic [7:0]        sy_p1_q  [LANES];
  logic [1:0]        cls_p1_d [LANES];
  logic [1:0]        cls_p1_q [LANES];

  logic [LANES-1:0]  sgn_p2_q, en_p2_q;
  logic signed [9:0] exp_p2_q  [LANES];
  logic [15:0]       prod_p2_d [LANES];
  logic [15:0]       prod_p2_q [LANES];
  logic [1:0]        cls_p2_q  [LANES];

  logic [DATA_W-1:0] r_d, r_q;
`ifdef BF16XN_MULT_FLAGS_EN
  logic [4*LANES-1:0] flags_d, flags_q;
`endif

  assign advance        = ~out_valid_q | s_if.out_ready;
  assign s_if.in_ready  = advance;
  assign s_if.out_valid = out_valid_q;
  assign s_if.R         = r_q;
`ifdef BF16XN_MULT_FLAGS_EN
  assign s_if.flags     = flags_q;
`endif

  // S1: unpack, classify, exponent sum
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sgn_p1_d[i] = x_p0_q[16*i+15] ^ y_p0_q[16*i+15];
      exp_p1_d[i] = $signed({2'b00, x_p0_q[16*i+7 +: 8]}) + $signed({2'b00, y_p0_q[16*i+7 +: 8]})
                    - 10'sd127;
      sx_p1_d[i]  = {1'b1, x_p0_q[16*i +: 7]};
      sy_p1_d[i]  = {1'b1, y_p0_q[16*i +: 7]};
      cls_p1_d[i] = classify_pair(x_p0_q[16*i +: 16], y_p0_q[16*i +: 16]);
    end
  end

  // S2: significand product
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_p2_d[i] = {8'd0, sx_p1_q[i]} * {8'd0, sy_p1_q[i]};
    end
  end

  // S3: normalise, round, special-case select, pack
  always_comb begin
    r_d = '0;
`ifdef BF16XN_MULT_FLAGS_EN
    flags_d = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      r_d[16*i +: 16] = sat_pack(sgn_p2_q[i], cls_p2_q[i], en_p2_q[i],
                                 round_rne(exp_p2_q[i], prod_p2_q[i]));
`ifdef BF16XN_MULT_FLAGS_EN
      flags_d[4*i +: 4] = lane_flags(cls_p2_q[i], en_p2_q[i],
                                     $signed(round_rne(exp_p2_q[i], prod_p2_q[i]) >> 7),
                                     prod_p2_q[i]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
`ifdef BF16XN_MULT_FLAGS_EN
      flags_q     <= '0;
`endif
    end else if (advance) begin
      vld_p0_q    <= s_if.in_valid;
      vld_p1_q    <= vld_p0_q;
      vld_p2_q    <= vld_p1_q;
      out_valid_q <= vld_p2_q;
      if (vld_p2_q) begin
        r_q     <= r_d;
`ifdef BF16XN_MULT_FLAGS_EN
        flags_q <= flags_d;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      if (s_if.in_valid) begin
        x_p0_q  <= s_if.X;
        y_p0_q  <= s_if.Y;
        en_p0_q <= s_if.lane_en;
      end
      sgn_p1_q  <= sgn_p1_d;
      exp_p1_q  <= exp_p1_d;
      sx_p1_q   <= sx_p1_d;
      sy_p1_q   <= sy_p1_d;
      cls_p1_q  <= cls_p1_d;
      en_p1_q   <= en_p0_q;
      sgn_p2_q  <= sgn_p1_q;
      exp_p2_q  <= exp_p1_q;
      prod_p2_q <= prod_p2_d;
      cls_p2_q  <= cls_p1_q;
      en_p2_q   <= en_p1_q;
    end
  end

endmodule

// File: tb/tb_bf16xn_mult_pipe.sv
// Directed self-checking bench for bf16xn_mult_pipe (two-lane and four-lane instances).
module tb_bf16xn_mult_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bf16xn_mult_pipe_if #(.LANES(2)) b2 ();
  bf16xn_mult_pipe_if #(.LANES(4)) b4 ();

  bf16xn_mult_pipe #(.LANES(2)) u_dut2 (.clk(clk), .rst(rst), .s_if(b2));
  bf16xn_mult_pipe #(.LANES(4)) u_dut4 (.clk(clk), .rst(rst), .s_if(b4));

  function automatic logic [63:0] beat4_x(input int k);
    logic [63:0] v;
    v = '0;
    for (int l = 0; l < 4; l++) v[16*l +: 16] = 16'h3F80 + 16'(8*k + l);
    return v;
  endfunction

  // Drives one beat on the two-lane DUT and waits (bounded) for its result.
  task automatic beat2(input logic [31:0] x, input logic [31:0] y, input logic [1:0] en,
                       output logic [31:0] r, output int lat);
    b2.X = x; b2.Y = y; b2.lane_en = en; b2.in_valid = 1'b1; b2.out_ready = 1'b1;
    @(posedge clk); #1;
    b2.in_valid = 1'b0; b2.X = '0; b2.Y = '0; b2.lane_en = '0;
    lat = 0;
    while (!b2.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    r = b2.R;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++; if (b2.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid2: got %b want 0", b2.out_valid); end
    n_tests++; if (b2.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready2: got %b want 1", b2.in_ready); end
    n_tests++; if (b2.R !== 32'h0) begin n_fail++; $display("FAIL reset_R2: got %h want 0", b2.R); end
    n_tests++; if (b4.out_valid !== 1'b0 || b4.R !== 64'h0) begin n_fail++; $display("FAIL reset_dut4: valid %b R %h want 0/0", b4.out_valid, b4.R); end
`ifdef BF16XN_MULT_FLAGS_EN
    n_tests++; if (b2.flags !== 8'h0) begin n_fail++; $display("FAIL reset_flags2: got %h want 0", b2.flags); end
`endif
  endtask

  task automatic test_basic();
    logic [31:0] r; int lat;
    beat2({16'h4040, 16'h3FC0}, {16'h4040, 16'h4000}, 2'b11, r, lat);
    n_tests++; if (r !== 32'h4110_4040) begin n_fail++; $display("FAIL basic_R: got %h want %h", r, 32'h41104040); end
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", lat); end
`ifdef BF16XN_MULT_FLAGS_EN
    n_tests++; if (b2.flags !== 8'h00) begin n_fail++; $display("FAIL basic_flags: got %h want 00", b2.flags); end
`endif
  endtask

  task automatic test_rne();
    logic [31:0] r; int lat;
    beat2({16'h3F80, 16'h3F81}, {16'h3F80, 16'h3FC0}, 2'b11, r, lat);
    n_tests++; if (r !== 32'h3F80_3FC2) begin n_fail++; $display("FAIL rne_tie_odd: got %h want %h", r, 32'h3F803FC2); end
    beat2({16'h3F80, 16'h3F83}, {16'h3F80, 16'h3FC0}, 2'b11, r, lat);
    n_tests++; if (r !== 32'h3F80_3FC4) begin n_fail++; $display("FAIL rne_tie_even: got %h want %h", r, 32'h3F803FC4); end
    beat2({16'h3F80, 16'h3F81}, {16'h3F80, 16'h3F81}, 2'b11, r, lat);
    n_tests++; if (r !== 32'h3F80_3F82) begin n_fail++; $display("FAIL rne_below_half: got %h want %h", r, 32'h3F803F82); end
`ifdef BF16XN_MULT_FLAGS_EN
    n_tests++; if (b2.flags !== 8'h01) begin n_fail++; $display("FAIL rne_inexact: got %h want 01", b2.flags); end
`endif
  endtask

  task automatic test_specials();
    logic [31:0] r; int lat;
    beat2({16'h0080, 16'h7F00}, {16'h3F00, 16'h4000}, 2'b11, r, lat);
    n_tests++; if (r !== 32'h0000_7F80) begin n_fail++; $display("FAIL spec_ovf_udf: got %h want %h", r, 32'h00007F80); end
`ifdef BF16XN_MULT_FLAGS_EN
    n_tests++; if (b2.flags !== 8'h35) begin n_fail++; $display("FAIL spec_ovf_udf_flags: got %h want 35", b2.flags); end
`endif
    beat2({16'hFF80, 16'h7F80}, {16'h3F80, 16'h0000}, 2'b11, r, lat);
    n_tests++; if (r !== 32'hFF80_7FC0) begin n_fail++; $display("FAIL spec_infzero_neginf: got %h want %h", r, 32'hFF807FC0); end
`ifdef BF16XN_MULT_FLAGS_EN
    n_tests++; if (b2.flags !== 8'h08) begin n_fail++; $display("FAIL spec_invalid_flags: got %h want 08", b2.flags); end
`endif
    beat2({16'h8000, 16'h7FC1}, {16'h4000, 16'h3F80}, 2'b11, r, lat);
    n_tests++; if (r !== 32'h8000_7FC0) begin n_fail++; $display("FAIL spec_nan_negzero: got %h want %h", r, 32'h80007FC0); end
  endtask

  task automatic test_lane_en();
    logic [31:0] r; int lat;
    beat2(32'h4000_4000, 32'h4000_4000, 2'b01, r, lat);
    n_tests++; if (r !== 32'h0000_4080) begin n_fail++; $display("FAIL lane_en_R: got %h want %h", r, 32'h00004080); end
`ifdef BF16XN_MULT_FLAGS_EN
    n_tests++; if (b2.flags !== 8'h00) begin n_fail++; $display("FAIL lane_en_flags: got %h want 00", b2.flags); end
`endif
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    logic [63:0] want;
    logic        stalled;
    int          sent, got, extra;
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      b4.out_ready = !(cyc >= 6 && cyc < 11);
      b4.in_valid  = (sent < 8);
      b4.X         = beat4_x(sent);
      b4.Y         = {4{16'h4000}};
      b4.lane_en   = 4'hF;
      @(negedge clk);
      if (stalled) begin
        n_tests++;
        if (b4.R !== held || b4.out_valid !== 1'b1) begin
          n_fail++; $display("FAIL bp_hold: R %h valid %b want %h valid 1", b4.R, b4.out_valid, held);
        end
      end
      stalled = b4.out_valid & ~b4.out_ready;
      if (stalled) begin
        held = b4.R;
        n_tests++;
        if (b4.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", b4.in_ready); end
      end
      if (b4.out_valid && b4.out_ready) begin
        want = beat4_x(got) + {4{16'h0080}};
        n_tests++;
        if (b4.R !== want) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", got, b4.R, want); end
        got++;
      end
      if (b4.in_valid && b4.in_ready) sent++;
      @(posedge clk); #1;
    end
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    n_tests++; if (got != 8) begin n_fail++; $display("FAIL bp_count: got %0d beats want 8", got); end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (b4.out_valid) extra++;
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL bp_duplicate: got %0d extra beats want 0", extra); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    logic [31:0] r; int lat; int seen;
    b2.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b2.X = {16'h3F80, 16'h3F80 + 16'(k)}; b2.Y = {2{16'h3F80}}; b2.lane_en = 2'b11; b2.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    b2.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (b2.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", b2.out_valid); end
    n_tests++; if (b2.R !== 32'h0) begin n_fail++; $display("FAIL midrst_R: got %h want 0", b2.R); end
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (b2.out_valid) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d stale beats want 0", seen); end
    beat2({16'h4040, 16'h3FC0}, {16'h4040, 16'h4000}, 2'b11, r, lat);
    n_tests++; if (r !== 32'h4110_4040) begin n_fail++; $display("FAIL midrst_after_R: got %h want %h", r, 32'h41104040); end
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL midrst_after_latency: got %0d want 3", lat); end
  endtask

  initial begin
    rst = 1'b1;
    b2.in_valid = 1'b0; b2.out_ready = 1'b1; b2.X = '0; b2.Y = '0; b2.lane_en = '0;
    b4.in_valid = 1'b0; b4.out_ready = 1'b1; b4.X = '0; b4.Y = '0; b4.lane_en = '0;
    test_reset();
    test_basic();
    test_rne();
    test_specials();
    test_lane_en();
    test_backpressure();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
